// File: rtl/regfile_mp.sv
// regfile_mp
//
// Multi-port integer register file with a busy scoreboard. Decode/issue
// reads operands and allocates destinations; writeback returns results on
// two write ports. Register 0 always reads as zero and is never busy.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, a same-cycle write to a register being read is forwarded
//   to the read outputs (write port 1 over write port 0).
//
// Ports:
//   i_clk          clock, all state updates on the rising edge
//   i_reset_n      synchronous active-low reset
//   i_rs_addr      NUM_RD packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   o_rs_data      NUM_RD packed read data, port p at [p*DATA_W +: DATA_W]
//   o_rs_busy      per read port: addressed register has a pending producer
//   i_wr0_*        write port 0 (enable, address, data)
//   i_wr1_*        write port 1 (enable, address, data), wins over port 0
//   i_alloc_en/addr  mark a register busy when its producer issues
//   o_busy_vec     registered scoreboard, bit r = register r busy

module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] i_rs_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rs_data,
    output logic [NUM_RD-1:0]        o_rs_busy,
    input  logic                     i_wr0_en,
    input  logic [ADDR_W-1:0]        i_wr0_addr,
    input  logic [DATA_W-1:0]        i_wr0_data,
    input  logic                     i_wr1_en,
    input  logic [ADDR_W-1:0]        i_wr1_addr,
    input  logic [DATA_W-1:0]        i_wr1_data,
    input  logic                     i_alloc_en,
    input  logic [ADDR_W-1:0]        i_alloc_addr,
    output logic [NUM_REGS-1:0]      o_busy_vec
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    // One-hot decodes of each write/alloc target; address 0 never decodes,
    // so register 0 is ignored by every update path.
    logic [NUM_REGS-1:0] wr0_hit;
    logic [NUM_REGS-1:0] wr1_hit;
    logic [NUM_REGS-1:0] alloc_hit;

    always_comb begin
        wr0_hit   = '0;
        wr1_hit   = '0;
        alloc_hit = '0;
        if (i_wr0_en && i_wr0_addr != '0)
            wr0_hit[i_wr0_addr] = 1'b1;
        if (i_wr1_en && i_wr1_addr != '0)
            wr1_hit[i_wr1_addr] = 1'b1;
        if (i_alloc_en && i_alloc_addr != '0)
            alloc_hit[i_alloc_addr] = 1'b1;
    end

    // Storage and scoreboard update. Write port 1 has priority on data;
    // an allocation in the same cycle as a write to that register leaves it
    // busy, since the new producer is younger than the one writing back.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
            busy <= '0;
        end else begin
            regs[0] <= '0;
            busy[0] <= 1'b0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (wr1_hit[r])
                    regs[r] <= i_wr1_data;
                else if (wr0_hit[r])
                    regs[r] <= i_wr0_data;

                if (alloc_hit[r])
                    busy[r] <= 1'b1;
                else if (wr0_hit[r] || wr1_hit[r])
                    busy[r] <= 1'b0;
            end
        end
    end

    assign o_busy_vec = busy;

    // Combinational read ports.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_data;
        logic              rd_busy;

        assign rd_addr = i_rs_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            rd_data = '0;
            rd_busy = 1'b0;
            if (rd_addr != '0) begin
                rd_data = regs[rd_addr];
                rd_busy = busy[rd_addr];
`ifdef REGFILE_BYPASS_EN
                // A result arriving this cycle satisfies the pending producer,
                // unless a new producer is allocated to the same register now.
                if (wr1_hit[rd_addr]) begin
                    rd_data = i_wr1_data;
                    rd_busy = alloc_hit[rd_addr];
                end else if (wr0_hit[rd_addr]) begin
                    rd_data = i_wr0_data;
                    rd_busy = alloc_hit[rd_addr];
                end
`endif
            end
        end

        assign o_rs_data[p*DATA_W +: DATA_W] = rd_data;
        assign o_rs_busy[p]                  = rd_busy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
//
// Directed self-checking bench for regfile_mp. A default-parameter instance
// covers reset, write conflicts, register 0, scoreboard and bypass; a second
// instance (64-bit, 16 registers, 4 read ports) is checked against a small
// reference model after random writes.

module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        reset_n;

    // Default instance: DATA_W 32, NUM_REGS 32, NUM_RD 2
    logic [9:0]  rs_addr;
    logic [63:0] rs_data;
    logic [1:0]  rs_busy;
    logic        wr0_en, wr1_en, alloc_en;
    logic [4:0]  wr0_addr, wr1_addr, alloc_addr;
    logic [31:0] wr0_data, wr1_data;
    logic [31:0] busy_vec;

    // Sweep instance: DATA_W 64, NUM_REGS 16, NUM_RD 4
    logic [15:0]  s_rs_addr;
    logic [255:0] s_rs_data;
    logic [3:0]   s_rs_busy;
    logic         s_wr0_en, s_wr1_en, s_alloc_en;
    logic [3:0]   s_wr0_addr, s_wr1_addr, s_alloc_addr;
    logic [63:0]  s_wr0_data, s_wr1_data;
    logic [15:0]  s_busy_vec;

    int tests_run;
    int tests_failed;

    regfile_mp dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_rs_addr    (rs_addr),
        .o_rs_data    (rs_data),
        .o_rs_busy    (rs_busy),
        .i_wr0_en     (wr0_en),
        .i_wr0_addr   (wr0_addr),
        .i_wr0_data   (wr0_data),
        .i_wr1_en     (wr1_en),
        .i_wr1_addr   (wr1_addr),
        .i_wr1_data   (wr1_data),
        .i_alloc_en   (alloc_en),
        .i_alloc_addr (alloc_addr),
        .o_busy_vec   (busy_vec)
    );

    regfile_mp #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(4)) dut_sweep (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_rs_addr    (s_rs_addr),
        .o_rs_data    (s_rs_data),
        .o_rs_busy    (s_rs_busy),
        .i_wr0_en     (s_wr0_en),
        .i_wr0_addr   (s_wr0_addr),
        .i_wr0_data   (s_wr0_data),
        .i_wr1_en     (s_wr1_en),
        .i_wr1_addr   (s_wr1_addr),
        .i_wr1_data   (s_wr1_data),
        .i_alloc_en   (s_alloc_en),
        .i_alloc_addr (s_alloc_addr),
        .o_busy_vec   (s_busy_vec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past the next rising edge; outputs are then sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        alloc_en = 1'b0; alloc_addr = '0;
    endtask

    task automatic set_rd(input int p, input logic [4:0] a);
        rs_addr[p*5 +: 5] = a;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        // State straight out of the initial reset
        set_rd(0, 5'd3); set_rd(1, 5'd17); #1;
        tests_run++;
        if (rs_data !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got %h, expected %h", rs_data, 64'h0);
        end
        tests_run++;
        if (busy_vec !== 32'h0 || rs_busy !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy: got %h/%b, expected 0/00", busy_vec, rs_busy);
        end

        // Populate state, then reset mid-operation with a write/alloc pending
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        alloc_en = 1'b1; alloc_addr = 5'd6;
        tick();
        idle_ports();
        set_rd(0, 5'd5); #1;
        got = rs_data[31:0];
        tests_run++;
        if (got !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_r5: got %h, expected %h", got, 32'hDEADBEEF);
        end
        tests_run++;
        if (busy_vec !== 32'h0000_0040) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_busy: got %h, expected %h", busy_vec, 32'h40);
        end

        reset_n = 1'b0;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'hCAFEF00D;
        alloc_en = 1'b1; alloc_addr = 5'd7;
        tick();
        reset_n = 1'b1;
        idle_ports();
        set_rd(0, 5'd5); set_rd(1, 5'd7); #1;
        tests_run++;
        if (rs_data !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_data: got %h, expected %h", rs_data, 64'h0);
        end
        tests_run++;
        if (busy_vec !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_busy: got %h, expected %h", busy_vec, 32'h0);
        end
    endtask

    task automatic test_dual_write();
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11111111;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22222222;
        tick();
        idle_ports();
        set_rd(0, 5'd7); #1;
        tests_run++;
        if (rs_data[31:0] !== 32'h22222222) begin
            tests_failed++;
            $display("[TB] FAIL same_addr_priority: got %h, expected %h", rs_data[31:0], 32'h22222222);
        end

        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hA;
        wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'hB;
        tick();
        idle_ports();
        set_rd(0, 5'd3); set_rd(1, 5'd4); #1;
        tests_run++;
        if (rs_data !== {32'hB, 32'hA}) begin
            tests_failed++;
            $display("[TB] FAIL dual_distinct: got %h, expected %h", rs_data, {32'hB, 32'hA});
        end
    endtask

    task automatic test_reg0();
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
        wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFFFFFF;
        alloc_en = 1'b1; alloc_addr = 5'd0;
        set_rd(0, 5'd0); set_rd(1, 5'd0); #1;
        // Even with bypass, a write to r0 is never forwarded
        tests_run++;
        if (rs_data !== 64'h0 || rs_busy !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL r0_same_cycle: got %h/%b, expected 0/00", rs_data, rs_busy);
        end
        tick();
        idle_ports(); #1;
        tests_run++;
        if (rs_data !== 64'h0 || rs_busy !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL r0_read: got %h/%b, expected 0/00", rs_data, rs_busy);
        end
        tests_run++;
        if (busy_vec !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL r0_busy_vec: got %h, expected %h", busy_vec, 32'h0);
        end
    endtask

    task automatic test_scoreboard();
        alloc_en = 1'b1; alloc_addr = 5'd9;
        tick();
        idle_ports();
        set_rd(0, 5'd9); set_rd(1, 5'd8); #1;
        tests_run++;
        if (busy_vec !== 32'h0000_0200 || rs_busy !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL alloc_r9: got %h/%b, expected 00000200/01", busy_vec, rs_busy);
        end

        // Alloc and write same register same edge: alloc wins, data written
        alloc_en = 1'b1; alloc_addr = 5'd9;
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h55;
        tick();
        idle_ports(); #1;
        tests_run++;
        if (busy_vec[9] !== 1'b1 || rs_data[31:0] !== 32'h55) begin
            tests_failed++;
            $display("[TB] FAIL alloc_vs_write: got busy %b data %h, expected 1 / 00000055", busy_vec[9], rs_data[31:0]);
        end

        // Re-alloc of an already busy register
        alloc_en = 1'b1; alloc_addr = 5'd9;
        tick();
        idle_ports(); #1;
        tests_run++;
        if (busy_vec !== 32'h0000_0200) begin
            tests_failed++;
            $display("[TB] FAIL realloc: got %h, expected %h", busy_vec, 32'h200);
        end

        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h66;
        tick();
        idle_ports(); #1;
        tests_run++;
        if (busy_vec !== 32'h0 || rs_busy !== 2'b00 || rs_data[31:0] !== 32'h66) begin
            tests_failed++;
            $display("[TB] FAIL wr1_clears_busy: got %h/%b/%h, expected 0/00/00000066", busy_vec, rs_busy, rs_data[31:0]);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_data;
        logic        exp_busy;

        set_rd(0, 5'd1); set_rd(1, 5'd12);
        wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 32'h1234;
        #1;
        exp_data = BYPASS ? 32'h1234 : 32'h0;
        tests_run++;
        if (rs_data[63:32] !== exp_data) begin
            tests_failed++;
            $display("[TB] FAIL bypass_same_cycle: got %h, expected %h", rs_data[63:32], exp_data);
        end
        tick();
        idle_ports(); #1;
        tests_run++;
        if (rs_data[63:32] !== 32'h1234) begin
            tests_failed++;
            $display("[TB] FAIL bypass_next_cycle: got %h, expected %h", rs_data[63:32], 32'h1234);
        end

        // Both write ports to the read address: port 1 forwarded
        set_rd(0, 5'd13);
        wr0_en = 1'b1; wr0_addr = 5'd13; wr0_data = 32'h1;
        wr1_en = 1'b1; wr1_addr = 5'd13; wr1_data = 32'h2;
        #1;
        exp_data = BYPASS ? 32'h2 : 32'h0;
        tests_run++;
        if (rs_data[31:0] !== exp_data) begin
            tests_failed++;
            $display("[TB] FAIL bypass_priority: got %h, expected %h", rs_data[31:0], exp_data);
        end
        tick();
        idle_ports();

        // Busy r14, then write it back while reading: forwarded write clears busy
        alloc_en = 1'b1; alloc_addr = 5'd14;
        tick();
        idle_ports();
        set_rd(0, 5'd14);
        wr0_en = 1'b1; wr0_addr = 5'd14; wr0_data = 32'h77;
        #1;
        exp_busy = BYPASS ? 1'b0 : 1'b1;
        tests_run++;
        if (rs_busy[0] !== exp_busy) begin
            tests_failed++;
            $display("[TB] FAIL bypass_busy_clear: got %b, expected %b", rs_busy[0], exp_busy);
        end
        // Same, but a new producer is allocated to r14 this cycle
        alloc_en = 1'b1; alloc_addr = 5'd14;
        #1;
        tests_run++;
        if (rs_busy[0] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bypass_busy_alloc: got %b, expected %b", rs_busy[0], 1'b1);
        end
        tick();
        idle_ports(); #1;
        tests_run++;
        if (rs_busy[0] !== 1'b1 || rs_data[31:0] !== 32'h77) begin
            tests_failed++;
            $display("[TB] FAIL bypass_after: got %b/%h, expected 1/00000077", rs_busy[0], rs_data[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp0, exp1;
        // Write every cycle on both ports: r16..r23 (port 0), r24..r31 (port 1)
        for (int i = 0; i < 8; i++) begin
            wr0_en = 1'b1; wr0_addr = 5'(16 + i); wr0_data = 32'h0101_0000 + 32'(i);
            wr1_en = 1'b1; wr1_addr = 5'(24 + i); wr1_data = 32'hF0F0_0000 + 32'(i);
            tick();
        end
        idle_ports();
        for (int i = 0; i < 8; i++) begin
            set_rd(0, 5'(16 + i)); set_rd(1, 5'(24 + i)); #1;
            exp0 = 32'h0101_0000 + 32'(i);
            exp1 = 32'hF0F0_0000 + 32'(i);
            tests_run++;
            if (rs_data !== {exp1, exp0}) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back[%0d]: got %h, expected %h", i, rs_data, {exp1, exp0});
            end
        end
    endtask

    task automatic test_param_sweep();
        logic [63:0] model [16];
        logic [3:0]  a;
        logic [63:0] got;
        for (int r = 0; r < 16; r++)
            model[r] = '0;

        for (int n = 0; n < 24; n++) begin
            s_wr0_en   = ($urandom_range(0, 3) != 0);
            s_wr0_addr = 4'($urandom_range(0, 15));
            s_wr0_data = {$urandom, $urandom};
            s_wr1_en   = ($urandom_range(0, 3) != 0);
            s_wr1_addr = (n % 4 == 0) ? s_wr0_addr : 4'($urandom_range(0, 15));
            s_wr1_data = {$urandom, $urandom};
            if (s_wr0_en && s_wr0_addr != 4'd0) model[s_wr0_addr] = s_wr0_data;
            if (s_wr1_en && s_wr1_addr != 4'd0) model[s_wr1_addr] = s_wr1_data;
            tick();
        end
        s_wr0_en = 1'b0; s_wr1_en = 1'b0;

        for (int pass = 0; pass < 2; pass++) begin
            for (int g = 0; g < 4; g++) begin
                for (int p = 0; p < 4; p++) begin
                    a = 4'(g * 4 + p);
                    if (pass == 1) a = 4'd15 - a;
                    s_rs_addr[p*4 +: 4] = a;
                end
                #1;
                for (int p = 0; p < 4; p++) begin
                    a = s_rs_addr[p*4 +: 4];
                    got = s_rs_data[p*64 +: 64];
                    tests_run++;
                    if (got !== model[a]) begin
                        tests_failed++;
                        $display("[TB] FAIL sweep port%0d r%0d: got %h, expected %h", p, a, got, model[a]);
                    end
                end
            end
        end
        tests_run++;
        if (s_busy_vec !== 16'h0 || s_rs_busy !== 4'h0) begin
            tests_failed++;
            $display("[TB] FAIL sweep_busy: got %h/%b, expected 0000/0000", s_busy_vec, s_rs_busy);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        rs_addr      = '0;
        idle_ports();
        s_rs_addr  = '0;
        s_wr0_en = 1'b0; s_wr0_addr = '0; s_wr0_data = '0;
        s_wr1_en = 1'b0; s_wr1_addr = '0; s_wr1_data = '0;
        s_alloc_en = 1'b0; s_alloc_addr = '0;
        tick();
        tick();
        reset_n = 1'b1;

        test_reset();
        test_dual_write();
        test_reg0();
        test_scoreboard();
        test_bypass();
        test_back_to_back();
        test_param_sweep();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
